// File: rtl/cook_controller_pkg.sv
// Shared types and constants for the microwave cook-time controller.
package cook_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SET   = 2'd1,
      ST_COOK  = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'd9;
   localparam logic [3:0] BCD_FIVE = 4'd5;

   function automatic logic is_digit(input logic [3:0] d);
      return d <= BCD_NINE;
   endfunction

endpackage

// File: rtl/cook_controller_bcd_down3.sv
// Combinational one-second decrement of an M:SS BCD time; flags a 0:00 result.
module bcd_down3
   import cook_controller_pkg::*;
(
   input  logic [3:0] min_in,
   input  logic [3:0] tens_in,
   input  logic [3:0] ones_in,
   output logic [3:0] min_out,
   output logic [3:0] tens_out,
   output logic [3:0] ones_out,
   output logic       zero_next
);

   always_comb begin
      min_out  = min_in;
      tens_out = tens_in;
      ones_out = ones_in;
      if (ones_in != '0) begin
         ones_out = ones_in - 4'd1;
      end else begin
         ones_out = BCD_NINE;
         // Borrowing from tens: entered tens of 6-9 simply count down.
         if (tens_in != '0) begin
            tens_out = tens_in - 4'd1;
         end else begin
            tens_out = BCD_FIVE;
            min_out  = min_in - 4'd1;
         end
      end
      zero_next = (min_out == '0) && (tens_out == '0) && (ones_out == '0);
   end

endmodule

// File: rtl/cook_controller.sv
// Keypad entry, start/stop/door sequencing and 1 Hz countdown for the microwave timer.
module cook_controller
   import cook_controller_pkg::*;
(
   input  logic       clk,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1hz,
   input  logic       startn,
   input  logic       stopn,
   input  logic       door_closed,
   output logic       enablen,
   output logic       mag_on,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       done
);

   state_t     state, state_nx;
   logic       loadn_q, startn_q, stopn_q, pgt_q;
   logic       ld_ev, st_ev, sp_ev, tk_ev, nz;
   logic [3:0] min_nx, tens_nx, ones_nx;
   logic [3:0] min_dec, tens_dec, ones_dec;
   logic       zero_next, done_nx;

   assign ld_ev = loadn_q & ~loadn;
   assign st_ev = startn_q & ~startn;
   assign sp_ev = stopn_q & ~stopn;
   assign tk_ev = ~pgt_q & pgt_1hz;
   assign nz    = (min_ones != '0) || (sec_tens != '0) || (sec_ones != '0);

   assign enablen = (state == ST_COOK) || (state == ST_PAUSE);
   assign mag_on  = (state == ST_COOK);

   bcd_down3 u_dec (
      .min_in    (min_ones),
      .tens_in   (sec_tens),
      .ones_in   (sec_ones),
      .min_out   (min_dec),
      .tens_out  (tens_dec),
      .ones_out  (ones_dec),
      .zero_next (zero_next)
   );

   always_ff @(posedge clk or negedge clearn) begin
      if (!clearn) begin
         state    <= ST_IDLE;
         min_ones <= '0;
         sec_tens <= '0;
         sec_ones <= '0;
         done     <= 1'b0;
         loadn_q  <= 1'b1;
         startn_q <= 1'b1;
         stopn_q  <= 1'b1;
         pgt_q    <= 1'b0;
      end else begin
         state    <= state_nx;
         min_ones <= min_nx;
         sec_tens <= tens_nx;
         sec_ones <= ones_nx;
         done     <= done_nx;
         loadn_q  <= loadn;
         startn_q <= startn;
         stopn_q  <= stopn;
         pgt_q    <= pgt_1hz;
      end
   end

   always_comb begin
      state_nx = state;
      min_nx   = min_ones;
      tens_nx  = sec_tens;
      ones_nx  = sec_ones;
      done_nx  = 1'b0;
      unique case (state)
         ST_IDLE, ST_SET: begin
            if (sp_ev) begin
               state_nx = ST_IDLE;
               min_nx   = '0;
               tens_nx  = '0;
               ones_nx  = '0;
            end else if (st_ev && door_closed && nz) begin
               state_nx = ST_COOK;
            end else if (ld_ev && is_digit(D)) begin
               state_nx = ST_SET;
               min_nx   = sec_tens;
               tens_nx  = sec_ones;
               ones_nx  = D;
            end
         end
         ST_COOK: begin
            // Door/stop win over a coincident tick so the time is held unchanged.
            if (!door_closed || sp_ev) begin
               state_nx = ST_PAUSE;
            end else if (tk_ev) begin
               min_nx  = min_dec;
               tens_nx = tens_dec;
               ones_nx = ones_dec;
               if (zero_next) begin
                  state_nx = ST_IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         ST_PAUSE: begin
            if (sp_ev) begin
               state_nx = ST_IDLE;
               min_nx   = '0;
               tens_nx  = '0;
               ones_nx  = '0;
            end else if (st_ev && door_closed) begin
               state_nx = ST_COOK;
            end
         end
      endcase
   end

endmodule
